imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory: receives a framed byte stream, packs

---
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and imem write port bundle for the boot loader
//
// Signals:
//   rx_valid  byte source has a byte on rx_data
//   rx_data   received byte
//   rx_ready  loader accepts a byte (transfer on rx_valid & rx_ready)
//   we        imem write strobe, one cycle per word
//   wa        imem byte address (word aligned)
//   wd        imem write data
// Modports:
//   master    byte source / imem side (drives rx_valid, rx_data)
//   slave     loader side (drives rx_ready, we, wa, wd)
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  we,
        input  wa,
        input  wd
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output we,
        output wa,
        output wd
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory word writer
//
// Receives LEN_LO, LEN_HI, 4*N data bytes (little-endian words) and an 8-bit
// additive checksum; writes each word to imem and releases the core only once
// a complete, checksum-valid image has been loaded.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     one-cycle pulse, begins frame reception from IDLE/DONE/ERR
//   bus       imem_loader_if.slave: rx_valid/rx_data/rx_ready byte stream,
//             we/wa/wd imem write port
//   cpu_hold  1 = keep core in reset
//   done      image loaded and checksum matched
//   err       frame rejected (length > DEPTH or checksum mismatch)
module imem_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int unsigned WCW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic [7:0]      csum_q, csum_d;
    // Lower three bytes of the word being assembled; the fourth byte is
    // merged directly into wd so the write issues the cycle after it arrives.
    logic [23:0]     shift_q, shift_d;
    logic            we_q, we_d;
    logic [31:0]     wa_q, wa_d;
    logic [31:0]     wd_q, wd_d;

    logic            rx_ready;
    logic            fire;
    logic [15:0]     len_full;
    logic            last_word;
    logic [31:0]     word_addr;

    assign fire      = bus.rx_valid & rx_ready;
    assign len_full  = {bus.rx_data, len_q[7:0]};
    assign last_word = (16'(word_cnt_q) + 16'd1) == len_q;
    assign word_addr = BASE_ADDR + {{(32-WCW-2){1'b0}}, word_cnt_q, 2'b00};

    // Status outputs are pure functions of the registered state.
    assign rx_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_hold = (state_q != S_DONE);

    assign bus.rx_ready = rx_ready;
    assign bus.we       = we_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        csum_d     = csum_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    len_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    csum_d     = 8'd0;
                    shift_d    = 24'd0;
                end
            end
            S_LEN0: begin
                if (fire) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (fire) begin
                    len_d = len_full;
                    if (len_full > 16'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    csum_d     = csum_q + bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        wa_d       = word_addr;
                        wd_d       = {bus.rx_data, shift_q};
                        word_cnt_d = word_cnt_q + 1'b1;
                        // Checksum byte may arrive during the write cycle.
                        if (last_word) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    shift_d[7:0]   = bus.rx_data;
                            2'd1:    shift_d[15:8]  = bus.rx_data;
                            default: shift_d[23:16] = bus.rx_data;
                        endcase
                    end
                end
            end
            S_CSUM: begin
                if (fire) begin
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
            csum_q     <= 8'd0;
            shift_q    <= 24'd0;
            we_q       <= 1'b0;
            wa_q       <= 32'd0;
            wd_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            csum_q     <= csum_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk;
    logic reset;
    logic start;
    logic cpu_hold;
    logic done;
    logic err;

    imem_loader_if bus();

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: tracks the frame as a list of consumed bytes.
    bit          m_act = 1'b0;
    int          m_res = 0;          // 0 none, 1 done, 2 err
    int          m_cons = 0;
    logic [15:0] m_len = 16'd0;
    logic [7:0]  m_sum = 8'd0;
    logic [31:0] m_word = 32'd0;
    bit          m_we = 1'b0;
    logic [31:0] m_wa = 32'd0;
    logic [31:0] m_wd = 32'd0;
    logic [63:0] obs_q[$];

    always @(negedge clk) begin
        chk("rx_ready", 32'(bus.rx_ready), 32'(m_act));
        chk("we", 32'(bus.we), 32'(m_we));
        chk("wa", bus.wa, m_wa);
        chk("wd", bus.wd, m_wd);
        chk("done", 32'(done), 32'(m_res == 1));
        chk("err", 32'(err), 32'(m_res == 2));
        chk("cpu_hold", 32'(cpu_hold), 32'(m_res != 1));
        if (bus.we) obs_q.push_back({bus.wa, bus.wd});

        m_we = 1'b0;
        if (reset) begin
            m_act = 1'b0;
            m_res = 0;
            m_wa  = 32'd0;
            m_wd  = 32'd0;
        end else if (!m_act && start) begin
            m_act  = 1'b1;
            m_cons = 0;
            m_sum  = 8'd0;
            m_res  = 0;
        end else if (m_act && bus.rx_valid) begin
            if (m_cons == 0) begin
                m_len[7:0] = bus.rx_data;
            end else if (m_cons == 1) begin
                m_len[15:8] = bus.rx_data;
                if (int'(m_len) > DEPTH) begin
                    m_act = 1'b0;
                    m_res = 2;
                end
            end else if (m_cons < 2 + 4 * int'(m_len)) begin
                int d;
                d = m_cons - 2;
                m_sum = m_sum + bus.rx_data;
                m_word[(d % 4) * 8 +: 8] = bus.rx_data;
                if (d % 4 == 3) begin
                    m_we = 1'b1;
                    m_wa = BASE + 32'(4 * (d / 4));
                    m_wd = m_word;
                end
            end else begin
                m_act = 1'b0;
                m_res = (bus.rx_data == m_sum) ? 1 : 2;
            end
            m_cons++;
        end
    end

    logic [7:0] frame_q[$];

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int n;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        start        = with_start;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.rx_ready) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL byte_timeout: got=no_accept want=accept at %0t", $time);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, input bit inject_start);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0,
                      inject_start && ($urandom_range(0, 7) == 0));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] s;
        logic [7:0] b;
        frame_q = {};
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n > DEPTH) return;
        s = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s = s + b;
            frame_q.push_back(b);
        end
        if (corrupt) s = s + 8'($urandom_range(1, 255));
        frame_q.push_back(s);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_wa", bus.wa, 32'd0);

        // Single word image.
        obs_q = {};
        pulse_start();
        frame_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h18};
        send_frame(0, 1'b0);
        chk("t1_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) begin
            chk("t1_wa", obs_q[0][63:32], 32'd0);
            chk("t1_wd", obs_q[0][31:0], 32'h0000_0513);
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);

        // Two words back to back.
        obs_q = {};
        pulse_start();
        frame_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'h10, 8'h20, 8'h30, 8'h40, 8'hAA};
        send_frame(0, 1'b0);
        chk("t2_nwr", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() == 2) begin
            chk("t2_wa0", obs_q[0][63:32], 32'd0);
            chk("t2_wd0", obs_q[0][31:0], 32'h0403_0201);
            chk("t2_wa1", obs_q[1][63:32], 32'd4);
            chk("t2_wd1", obs_q[1][31:0], 32'h4030_2010);
        end
        chk("t2_done", 32'(done), 32'd1);

        // Oversized length.
        obs_q = {};
        pulse_start();
        frame_q = '{8'h41, 8'h00};
        send_frame(0, 1'b0);
        chk("t3_nwr", 32'(obs_q.size()), 32'd0);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_hold", 32'(cpu_hold), 32'd1);

        // Bad checksum.
        obs_q = {};
        pulse_start();
        frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        send_frame(0, 1'b0);
        chk("t4_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) chk("t4_wd", obs_q[0][31:0], 32'hDDCC_BBAA);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_done", 32'(done), 32'd0);

        // Empty image, back to back then one byte every 5 cycles.
        for (int g = 0; g < 2; g++) begin
            obs_q = {};
            pulse_start();
            frame_q = '{8'h00, 8'h00, 8'h00};
            foreach (frame_q[i]) send_byte(frame_q[i], 4 * g, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            chk("t5_nwr", 32'(obs_q.size()), 32'd0);
            chk("t5_done", 32'(done), 32'd1);
        end

        // Reset mid-frame, then a fresh load.
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("t6_we", 32'(bus.we), 32'd0);
        chk("t6_wd", bus.wd, 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_hold", 32'(cpu_hold), 32'd1);
        obs_q = {};
        pulse_start();
        frame_q = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hA3};
        send_frame(0, 1'b0);
        chk("t6_nwr", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) chk("t6_wd1", obs_q[0][31:0], 32'h0010_0093);
        chk("t6_done2", 32'(done), 32'd1);

        // Full-depth image.
        obs_q = {};
        pulse_start();
        build_frame(DEPTH, 1'b0);
        send_frame(0, 1'b0);
        chk("full_nwr", 32'(obs_q.size()), 32'(DEPTH));
        if (obs_q.size() == DEPTH) chk("full_last_wa", obs_q[DEPTH-1][63:32], 32'(4 * (DEPTH - 1)));
        chk("full_done", 32'(done), 32'd1);

        // Random frames, gaps and stray start pulses.
        for (int k = 0; k < 40; k++) begin
            int n;
            case ($urandom_range(0, 9))
                0:       n = DEPTH + 1;
                1:       n = 256 + int'($urandom_range(0, 3));
                default: n = int'($urandom_range(0, 6));
            endcase
            pulse_start();
            build_frame(n, $urandom_range(0, 3) == 0);
            send_frame(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
